sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 115 +++++++++++
 tb/tb_sync_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered occupancy flags
// and sticky overflow/underflow error bits.
module sync_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ASIZE    = 4,
  parameter int unsigned AF_LEVEL = (1 << ASIZE) - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrt_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  typedef logic [ASIZE:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t             wptr_q, wptr_d;
  ptr_t             rptr_q, rptr_d;
  ptr_t             count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_acc, wr_acc;

  // A read frees a slot in the same edge, so a full FIFO still accepts a write.
  assign rd_acc = rd_en && !empty_q;
  assign wr_acc = wrt_en && (!full_q || rd_acc);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) begin
      rptr_d     = rptr_q + 1'b1;
      data_out_d = mem_q[rptr_q[ASIZE-1:0]];
    end

    // Clear first so a coincident error condition wins.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wrt_en && full_q && !rd_acc) overflow_d  = 1'b1;
    if (rd_en && empty_q)            underflow_d = 1'b1;

    count_d        = wptr_d - rptr_d;
    full_d         = (count_d == ptr_t'(DEPTH));
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= ptr_t'(AF_LEVEL));
    almost_empty_d = (count_d <= ptr_t'(AE_LEVEL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      data_out_q     <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[ASIZE-1:0]] <= data_in;
  end

  assign data_out     = data_out_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DEPTH=16, AF=14, AE=2) against a queue model.
module tb_sync_fifo;

  logic       clk, rst, wrt_en, rd_en, clr_err;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_udf;

  localparam logic [18:0] RESET_VEC = {8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  sync_fifo #(.WIDTH(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .wrt_en(wrt_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [18:0] obs = {data_out, count, full, empty, almost_full, almost_empty, overflow, underflow};

  function automatic logic [18:0] exp_vec();
    int n = q.size();
    return {m_dout, 5'(n), n == 16, n == 0, n >= 14, n <= 2, m_ovf, m_udf};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Drive one cycle of requests, advance the model at the edge, sample 1 time unit later.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit racc, wacc;
    wrt_en = w; data_in = d; rd_en = r; clr_err = c;
    @(posedge clk);
    racc = r && (q.size() > 0);
    wacc = w && (q.size() < 16 || racc);
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (w && q.size() == 16 && !racc) m_ovf = 1'b1;
    if (r && q.size() == 0) m_udf = 1'b1;
    if (racc) m_dout = q.pop_front();
    if (wacc) q.push_back(d);
    #1;
    wrt_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
  endtask

  task automatic drain_all();
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    checks++;
    if ({full, count} !== {1'b1, 5'd16}) begin
      errors++;
      $display("FAIL fill_full got %b/%0d exp 1/16", full, count);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (data_out !== 8'(i)) begin
        errors++;
        $display("FAIL drain_order got %h exp %h", data_out, 8'(i));
      end
    end
    checks++;
    if ({empty, count} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL drain_empty got %b/%0d exp 1/0", empty, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    checks++;
    if ({full, overflow, count} !== {1'b1, 1'b1, 5'd16}) begin
      errors++;
      $display("FAIL overflow_set got %b%b/%0d exp 11/16", full, overflow, count);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (data_out !== 8'h40 + 8'(i)) begin
        errors++;
        $display("FAIL overflow_data got %h exp %h", data_out, 8'h40 + 8'(i));
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %b exp 1", overflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr got %b exp 0", overflow);
    end
    // Set condition coincident with clear must leave the flag set.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clr got %b exp 1", underflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      errors++;
      $display("FAIL err_clr got %b%b exp 00", overflow, underflow);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    checks++;
    if ({data_out, count, full, overflow} !== {8'h20, 5'd16, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_rw got %h/%0d/%b/%b exp 20/16/1/0", data_out, count, full, overflow);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (data_out !== ((i == 16) ? 8'h99 : 8'h20 + 8'(i))) begin
        errors++;
        $display("FAIL full_rw_order got %h exp %h", data_out, (i == 16) ? 8'h99 : 8'h20 + 8'(i));
      end
    end
  endtask

  task automatic test_empty_rw();
    logic [7:0] prev;
    prev = data_out;
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    checks++;
    if ({underflow, data_out, count} !== {1'b1, prev, 5'd1}) begin
      errors++;
      $display("FAIL empty_rw got %b/%h/%0d exp 1/%h/1", underflow, data_out, count, prev);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'hAA) begin
      errors++;
      $display("FAIL empty_rw_read got %h exp aa", data_out);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_sweep();
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 16; k++) begin
        step(1'b1, 8'(r * 16 + k), 1'b0, 1'b0);
        checks++;
        if ({almost_empty, almost_full, count} !== {k <= 2, k >= 14, 5'(k)}) begin
          errors++;
          $display("FAIL sweep_up k=%0d got %b%b/%0d", k, almost_empty, almost_full, count);
        end
      end
      for (int k = 15; k >= 0; k--) begin
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({almost_empty, almost_full, count, data_out} !==
            {k <= 2, k >= 14, 5'(k), 8'(r * 16 + 16 - k)}) begin
          errors++;
          $display("FAIL sweep_down k=%0d got %b%b/%0d/%h exp data %h",
                   k, almost_empty, almost_full, count, data_out, 8'(r * 16 + 16 - k));
        end
      end
    end
  endtask

  task automatic test_random();
    int bias;
    for (int i = 0; i < 600; i++) begin
      bias = ((i / 100) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) < (100 - bias),
           $urandom_range(0, 19) == 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got %h exp %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    drain_all();
    for (int i = 0; i < 9; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", obs, RESET_VEC);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'h5B, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({data_out, count} !== {8'h5A, 5'd1}) begin
      errors++;
      $display("FAIL post_reset got %h/%0d exp 5a/1", data_out, count);
    end
  endtask

  initial begin
    rst = 1'b1; wrt_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    model_reset();
    #3;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_sweep();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
